// File: rtl/acia_master.sv
// Bus initiator for a 6850-style ACIA: master reset, configure, then poll status and move bytes
// between the ACIA data register and a pair of valid/ready byte streams. Optional macro: ACIA_MASTER_ERRCNT_EN.
module acia_master #(
    parameter logic [7:0] CTRL_WORD = 8'h15,
    parameter int         POLL_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       acia_cs,
    output logic       acia_we,
    output logic       acia_rs,
    output logic [7:0] acia_din,
    input  logic [7:0] acia_dout,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       init_done
`ifdef ACIA_MASTER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [2:0] {
        RST_WR, CFG_WR, GAP, STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT, DATA_WR
    } state_t;

    // With no gap the poll loop skips GAP entirely.
    localparam state_t     IDLE_NEXT = (POLL_GAP == 0) ? STAT_RD : GAP;
    localparam logic [7:0] GAP_LOAD  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    state_t     state_q, state_d;
    logic       started_q;
    logic [7:0] gap_q, gap_d;
    logic       cs_q, we_q, rs_q;
    logic [7:0] din_q;
    logic       cs_d, we_d, rs_d;
    logic [7:0] din_d;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       init_done_q;
    logic       take_rx, take_tx;
    logic       unused_status;

    assign take_rx  = acia_dout[0] & ~rx_valid_q;
    assign take_tx  = acia_dout[1] & tx_valid & ~take_rx;
    assign tx_ready = (state_q == STAT_WAIT) & take_tx;
    assign unused_status = ^acia_dout[7:2];

    // started_q holds the FSM in RST_WR for one cycle so the master-reset strobe is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_WR;
            started_q <= 1'b0;
            gap_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            RST_WR:    if (started_q) state_d = CFG_WR;
            CFG_WR:    begin state_d = IDLE_NEXT; gap_d = GAP_LOAD; end
            GAP:       if (gap_q == 8'd0) state_d = STAT_RD;
                       else               gap_d   = gap_q - 8'd1;
            STAT_RD:   state_d = STAT_WAIT;
            STAT_WAIT: if (take_rx)      state_d = DATA_RD;
                       else if (take_tx) state_d = DATA_WR;
                       else begin state_d = IDLE_NEXT; gap_d = GAP_LOAD; end
            DATA_RD:   state_d = DATA_WAIT;
            DATA_WAIT: begin state_d = IDLE_NEXT; gap_d = GAP_LOAD; end
            DATA_WR:   begin state_d = IDLE_NEXT; gap_d = GAP_LOAD; end
            default:   state_d = RST_WR;
        endcase
    end

    // Bus strobes are decoded from the next state so the registered bus lines up with the state.
    always_comb begin
        cs_d  = 1'b0;
        we_d  = 1'b0;
        rs_d  = 1'b0;
        din_d = 8'h00;
        case (state_d)
            RST_WR:  begin cs_d = 1'b1; we_d = 1'b1; din_d = 8'h03; end
            CFG_WR:  begin cs_d = 1'b1; we_d = 1'b1; din_d = CTRL_WORD; end
            STAT_RD: cs_d = 1'b1;
            DATA_RD: begin cs_d = 1'b1; rs_d = 1'b1; end
            DATA_WR: begin cs_d = 1'b1; we_d = 1'b1; rs_d = 1'b1; din_d = tx_data; end
            default: cs_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            rs_q        <= 1'b0;
            din_q       <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            we_q        <= we_d;
            rs_q        <= rs_d;
            din_q       <= din_d;
            init_done_q <= init_done_q | (state_q == CFG_WR);
            if (state_q == DATA_WAIT) begin
                rx_data_q  <= acia_dout;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign acia_cs   = cs_q;
    assign acia_we   = we_q;
    assign acia_rs   = rs_q;
    assign acia_din  = din_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;

`ifdef ACIA_MASTER_ERRCNT_EN
    logic       err_prev_q;
    logic [7:0] err_count_q;

    // Counts rising edges of status bit 4 as seen across successive polls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_prev_q  <= 1'b0;
            err_count_q <= 8'h00;
        end else if (state_q == STAT_WAIT) begin
            err_prev_q <= acia_dout[4];
            if (acia_dout[4] && !err_prev_q && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_acia_master.sv
// Directed bench for acia_master: small ACIA register model, per-poll vector table, init and reset sequences.
module tb_acia_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       acia_cs, acia_we, acia_rs;
    logic [7:0] acia_din;
    logic [7:0] acia_dout = 8'h00;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready  = 1'b0;
    logic       init_done;
`ifdef ACIA_MASTER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    logic [7:0] m_status = 8'h00;
    logic [7:0] m_data   = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    acia_master dut (
        .clk       (clk),
        .rst       (rst),
        .acia_cs   (acia_cs),
        .acia_we   (acia_we),
        .acia_rs   (acia_rs),
        .acia_din  (acia_din),
        .acia_dout (acia_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .init_done (init_done)
`ifdef ACIA_MASTER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // ACIA read data is registered on the read strobe.
    always @(posedge clk) begin
        if (acia_cs && !acia_we)
            acia_dout <= acia_rs ? m_data : m_status;
    end

    typedef struct {
        logic [7:0] status;
        logic [7:0] data;
        logic       txv;
        logic [7:0] txd;
        logic       rxr;
        int         rd;
        int         wr;
        logic [7:0] din;
        int         txr;
        int         rise;
        int         fall;
        logic [7:0] rxd;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_stat_rd();
        return acia_cs && !acia_we && !acia_rs;
    endfunction

    // Called on the negedge where rst has just been released; returns on the first STAT_RD cycle.
    task automatic check_init(input string tag);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            case (c)
                0: chk({tag, "_c0_bus"}, {acia_cs, acia_we, acia_rs, acia_din}, {3'b110, 8'h03});
                1: begin
                    chk({tag, "_c1_bus"}, {acia_cs, acia_we, acia_rs, acia_din}, {3'b110, 8'h15});
                    chk({tag, "_c1_init_done"}, init_done, 1'b0);
                end
                2: chk({tag, "_c2_init_done_idle"}, {init_done, acia_cs}, 2'b10);
                5: chk({tag, "_c5_idle"}, acia_cs, 1'b0);
                6: chk({tag, "_c6_stat_rd"}, is_stat_rd(), 1'b1);
                default: ;
            endcase
        end
    endtask

    // Starts on a STAT_RD negedge, observes one full poll, ends on the next STAT_RD negedge.
    task automatic run_poll(input vec_t v, output int rd, output int wr, output logic [7:0] din,
                            output int txr, output int rise, output int fall, output int wrc,
                            output int viol, output bit to);
        logic prev;
        bit   drop;
        m_status = v.status;
        m_data   = v.data;
        tx_valid = v.txv;
        tx_data  = v.txd;
        rx_ready = v.rxr;
        rd = 0; wr = 0; din = 8'h00; txr = 0; rise = -1; fall = -1; wrc = -1; viol = 0; to = 1'b1;
        prev = rx_valid;
        drop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                if (drop) begin
                    tx_valid = 1'b0;
                    drop = 1'b0;
                end
                if (is_stat_rd()) begin
                    to = 1'b0;
                    return;
                end
            end
            if (acia_cs && !acia_we && acia_rs) rd++;
            if (acia_cs && acia_we && acia_rs) begin
                wr++;
                din = acia_din;
                wrc = c;
            end
            if (tx_ready) begin
                txr++;
                drop = 1'b1;
            end
            if (!acia_cs && (acia_we || acia_din != 8'h00)) viol++;
            if (rx_valid && !prev && rise < 0) rise = c;
            if (!rx_valid && prev && fall < 0) fall = c;
            prev = rx_valid;
            @(negedge clk);
        end
    endtask

    initial begin
        int rd, wr, txr, rise, fall, wrc, viol;
        logic [7:0] din;
        bit to, found;
        vec_t ev;

        //          status  data   txv   txd    rxr   rd wr din    txr rise fall rxd
        tv[0]  = '{8'h02, 8'h00, 1'b1, 8'hA5, 1'b1, 0, 1, 8'hA5, 1, -1, -1, 8'h00};
        tv[1]  = '{8'h01, 8'h5A, 1'b0, 8'h00, 1'b1, 1, 0, 8'h00, 0,  4,  5, 8'h5A};
        tv[2]  = '{8'h00, 8'h00, 1'b1, 8'h33, 1'b1, 0, 0, 8'h00, 0, -1, -1, 8'h5A};
        tv[3]  = '{8'h03, 8'h77, 1'b1, 8'h11, 1'b0, 1, 0, 8'h00, 0,  4, -1, 8'h77};
        tv[4]  = '{8'h03, 8'h88, 1'b1, 8'h11, 1'b0, 0, 1, 8'h11, 1, -1, -1, 8'h77};
        tv[5]  = '{8'h01, 8'h99, 1'b0, 8'h00, 1'b0, 0, 0, 8'h00, 0, -1, -1, 8'h77};
        tv[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 0, 0, 8'h00, 0, -1,  1, 8'h77};
        tv[7]  = '{8'h03, 8'hC3, 1'b1, 8'h44, 1'b1, 1, 0, 8'h00, 0,  4,  5, 8'hC3};
        tv[8]  = '{8'h02, 8'h00, 1'b1, 8'h44, 1'b1, 0, 1, 8'h44, 1, -1, -1, 8'hC3};
        tv[9]  = '{8'h02, 8'h00, 1'b0, 8'h00, 1'b1, 0, 0, 8'h00, 0, -1, -1, 8'hC3};
        tv[10] = '{8'h01, 8'h66, 1'b0, 8'h00, 1'b0, 1, 0, 8'h00, 0,  4, -1, 8'h66};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {acia_cs, acia_we, acia_rs, acia_din, rx_data, rx_valid, init_done}, 20'h0);
        rst = 1'b0;
        check_init("init");

        for (int i = 0; i < 11; i++) begin
            run_poll(tv[i], rd, wr, din, txr, rise, fall, wrc, viol, to);
            chk($sformatf("v%0d_timeout", i), to, 1'b0);
            chk($sformatf("v%0d_data_reads", i), rd, tv[i].rd);
            chk($sformatf("v%0d_data_writes", i), wr, tv[i].wr);
            chk($sformatf("v%0d_write_byte", i), din, tv[i].din);
            chk($sformatf("v%0d_write_cycle", i), wrc, (tv[i].wr != 0) ? 2 : -1);
            chk($sformatf("v%0d_tx_ready_pulses", i), txr, tv[i].txr);
            chk($sformatf("v%0d_rx_rise_cycle", i), rise, tv[i].rise);
            chk($sformatf("v%0d_rx_fall_cycle", i), fall, tv[i].fall);
            chk($sformatf("v%0d_rx_data", i), rx_data, tv[i].rxd);
            chk($sformatf("v%0d_idle_bus", i), viol, 0);
        end

        // Reset during the write strobe, with a received byte still pending.
        m_status = 8'h02;
        tx_data  = 8'h9C;
        tx_valid = 1'b1;
        rx_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (acia_cs && acia_we && acia_rs) found = 1'b1;
        end
        chk("midreset_write_seen", {found, acia_din}, {1'b1, 8'h9C});
        rst = 1'b1;
        #1;
        chk("midreset_abort", {acia_cs, acia_we, acia_din, rx_valid, init_done}, 12'h0);
        @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b0;
        check_init("reinit");

`ifdef ACIA_MASTER_ERRCNT_EN
        ev = '{8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 0, 0, 8'h00, 0, -1, -1, 8'h00};
        run_poll(ev, rd, wr, din, txr, rise, fall, wrc, viol, to);
        chk("err_poll1_timeout", to, 1'b0);
        chk("err_after_first", err_count, 8'd1);
        run_poll(ev, rd, wr, din, txr, rise, fall, wrc, viol, to);
        ev.status = 8'h00;
        run_poll(ev, rd, wr, din, txr, rise, fall, wrc, viol, to);
        ev.status = 8'h10;
        run_poll(ev, rd, wr, din, txr, rise, fall, wrc, viol, to);
        chk("err_poll4_timeout", to, 1'b0);
        chk("err_count_final", err_count, 8'd2);
`else
        ev = '{8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 0, 0, 8'h00, 0, -1, -1, 8'h00};
        run_poll(ev, rd, wr, din, txr, rise, fall, wrc, viol, to);
        chk("stat10_timeout", to, 1'b0);
        chk("stat10_no_access", rd + wr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
